// File: rtl/gate3_bist_pkg.sv
// gate3_bist_pkg: shared FSM encoding, pattern count and expected gate response
package gate3_bist_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, APPLY = 2'd1, DONE = 2'd2} state_t;
  localparam int NUM_PAT = 8;
  function automatic logic [1:0] exp_resp(input logic [2:0] p);
    return {&p, ~&p};
  endfunction
endpackage

// File: rtl/gate3_bist_ctrl_if.sv
// gate3_bist_ctrl_if: control, stimulus and status bundle of the 3-input gate BIST
interface gate3_bist_ctrl_if;
  logic start, abort, a, b, c, d, e, busy, done, pass;
  logic [3:0] err_cnt;
  logic [7:0] fail_vec;
  logic [2:0] pat_idx;
  modport master(output start, abort, d, e, input a, b, c, busy, done, pass, err_cnt, fail_vec, pat_idx);
  modport slave(input start, abort, d, e, output a, b, c, busy, done, pass, err_cnt, fail_vec, pat_idx);
endinterface

// File: rtl/gate3_dwell_cnt.sv
// gate3_dwell_cnt: dwell counter with clear, enable and terminal flag at DWELL-1
module gate3_dwell_cnt #(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  assign tc = cnt == CNT_W'(DWELL - 1);
endmodule

// File: rtl/gate3_bist_ctrl.sv
// gate3_bist_ctrl: walks patterns 0..7 into a 3-input AND/NAND gate and scores its responses
module gate3_bist_ctrl
  import gate3_bist_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst,
  gate3_bist_ctrl_if.slave bus
);
  state_t state, nxt;
  logic [2:0] pidx, abc_n;
  logic [3:0] err;
  logic [7:0] fail;
  logic pass_r, tc, go, cmp, mis, busy_n, done_n, pass_n;
  assign go  = state == IDLE && bus.start;
  assign cmp = state == APPLY && tc && !bus.abort;
  assign mis = {bus.d, bus.e} != exp_resp(pidx);
  gate3_dwell_cnt #(.DWELL(DWELL), .CNT_W(CNT_W)) u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(state != APPLY || cmp),
    .en(state == APPLY),
    .tc(tc)
  );
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = state == IDLE  ? (bus.start ? APPLY : IDLE) :
          state == APPLY ? (bus.abort ? IDLE : (cmp && pidx == 3'(NUM_PAT - 1)) ? DONE : APPLY) :
          IDLE;
  // abort suppresses cmp, so a compare landing on the abort cycle is dropped
  always_ff @(posedge clk)
    if (rst || go) begin
      pidx   <= '0;
      err    <= '0;
      fail   <= '0;
      pass_r <= 1'b0;
    end else if (cmp) begin
      if (mis) begin
        fail[pidx] <= 1'b1;
        err        <= err == 4'd8 ? err : err + 4'd1;
      end
      pidx <= pidx == 3'(NUM_PAT - 1) ? pidx : pidx + 3'd1;
    end else if (state == DONE) pass_r <= err == 4'd0;
  always_comb begin
    busy_n = state == APPLY;
    done_n = state == DONE;
    abc_n  = state == APPLY ? pidx : 3'd0;
    pass_n = state == DONE ? err == 4'd0 : pass_r;
  end
  // every output is a register of the current-state view, so outputs trail the FSM by one cycle
  always_ff @(posedge clk)
    if (rst) begin
      {bus.a, bus.b, bus.c} <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.pass     <= 1'b0;
      bus.err_cnt  <= '0;
      bus.fail_vec <= '0;
      bus.pat_idx  <= '0;
    end else begin
      {bus.a, bus.b, bus.c} <= abc_n;
      bus.busy     <= busy_n;
      bus.done     <= done_n;
      bus.pass     <= pass_n;
      bus.err_cnt  <= err;
      bus.fail_vec <= fail;
      bus.pat_idx  <= pidx;
    end
endmodule
